// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage definitions: state encodings and fetch constants used by fetch and decode.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running, wrapping event counters for the fetch stage (built only with FETCH_PERF_EN).
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_fetched_i,
    input  logic        inc_stall_i,
    input  logic        inc_redirect_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stalls_o,
    output logic [31:0] perf_redirects_o
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        fetched_d   = fetched_q + {31'd0, inc_fetched_i};
        stalls_d    = stalls_q + {31'd0, inc_stall_i};
        redirects_d = redirects_q + {31'd0, inc_redirect_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= 32'd0;
            stalls_q    <= 32'd0;
            redirects_q <= 32'd0;
        end else begin
            fetched_q   <= fetched_d;
            stalls_q    <= stalls_d;
            redirects_q <= redirects_d;
        end
    end

    assign perf_fetched_o   = fetched_q;
    assign perf_stalls_o    = stalls_q;
    assign perf_redirects_o = redirects_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, drives a 1-cycle synchronous instruction memory and pairs each
// returned word with its PC. Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_redirects
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         req_valid_q, req_valid_d;
    logic         fault_q, fault_d;

    logic redir_ok;
    logic redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && !redir_ok;

    // Whenever the PC does not move, re-present the in-flight address so id_* stays stable.
    always_comb begin
        if (redir_ok) begin
            imem_pc = redirect_pc;
        end else if (stall || (state_q == StHalt) || redir_bad) begin
            imem_pc = req_pc_q;
        end else begin
            imem_pc = pc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        fault_d     = fault_q;
        if (redir_ok) begin
            req_pc_d    = redirect_pc;
            req_valid_d = 1'b1;
            pc_d        = redirect_pc + PC_STEP;
            state_d     = StRun;
            fault_d     = 1'b0;
        end else if (redir_bad) begin
            state_d     = StHalt;
            fault_d     = 1'b1;
            req_valid_d = 1'b0;
        end else if (halt) begin
            state_d     = StHalt;
            req_valid_d = 1'b0;
        end else if (!stall && (state_q != StHalt)) begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign id_valid       = req_valid_q;
    assign id_instruction = req_valid_q ? imem_instruction : NOP_INSTR;
    assign id_pc          = req_pc_q;
    assign id_pc_plus4    = req_pc_q + PC_STEP;
    assign fault          = fault_q;

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk              (clk),
        .reset            (reset),
        .inc_fetched_i    (req_valid_q && !stall),
        .inc_stall_i      (stall && (state_q == StRun)),
        .inc_redirect_i   (redir_ok),
        .perf_fetched_o   (perf_fetched),
        .perf_stalls_o    (perf_stalls),
        .perf_redirects_o (perf_redirects)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random control traffic, checked
// against a behavioural fetch model; a second instance checks PC wrap from RESET_PC=FFFF_FFFC.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction = 32'h0;
    logic        id_valid;
    logic [31:0] id_instruction, id_pc, id_pc_plus4;
    logic        fault;

    logic        w_reset = 1'b1;
    logic [31:0] w_imem_pc, w_id_instruction, w_id_pc, w_id_pc_plus4;
    logic        w_id_valid, w_fault;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_redirects;
    logic [31:0] w_pf, w_ps, w_pr;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .halt             (halt),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .id_valid         (id_valid),
        .id_instruction   (id_instruction),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .fault            (fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_stalls      (perf_stalls),
        .perf_redirects   (perf_redirects)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk              (clk),
        .reset            (w_reset),
        .stall            (1'b0),
        .redirect         (1'b0),
        .redirect_pc      (32'h0),
        .halt             (1'b0),
        .imem_pc          (w_imem_pc),
        .imem_instruction (32'h1234_5678),
        .id_valid         (w_id_valid),
        .id_instruction   (w_id_instruction),
        .id_pc            (w_id_pc),
        .id_pc_plus4      (w_id_pc_plus4),
        .fault            (w_fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (w_pf),
        .perf_stalls      (w_ps),
        .perf_redirects   (w_pr)
`endif
    );

    // Instruction memory contents: the two known words, hashed filler elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h3408_0006;
        if (addr == 32'h4) return 32'hAC08_0000;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    always @(posedge clk) imem_instruction <= mem_word(imem_pc);

    typedef struct {
        logic [31:0] imem_pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fault;
        logic [31:0] pf;
        logic [31:0] ps;
        logic [31:0] pr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: what address is being shown, what comes next, and whether fetch stopped.
    bit          m_halted, m_boot, m_shown_valid, m_fault;
    logic [31:0] m_shown, m_next;
    logic [31:0] m_pf, m_ps, m_pr;

    task automatic model_reset(input logic [31:0] rpc);
        m_halted = 0; m_boot = 1; m_shown_valid = 0; m_fault = 0;
        m_shown = rpc; m_next = rpc;
        m_pf = 0; m_ps = 0; m_pr = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit hl);
        exp_t e;
        bit   good;
        @(posedge clk);
        #2;
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
        good = rd && (rpc % 4 == 0);
        if (good) e.imem_pc = rpc;
        else if (st || m_halted || rd) e.imem_pc = m_shown;
        else e.imem_pc = m_next;
        e.valid = m_shown_valid;
        e.pc    = m_shown;
        e.pc4   = m_shown + 4;
        e.instr = m_shown_valid ? mem_word(m_shown) : 32'h0;
        e.fault = m_fault;
        e.pf = m_pf; e.ps = m_ps; e.pr = m_pr;
        exp_q.push_back(e);
        // Counters see this cycle's activity at the coming edge.
        if (m_shown_valid && !st) m_pf++;
        if (st && !m_boot && !m_halted) m_ps++;
        if (good) m_pr++;
        if (rst) begin
            model_reset(32'h0);
        end else if (good) begin
            m_shown = rpc; m_shown_valid = 1; m_next = rpc + 4;
            m_halted = 0; m_boot = 0; m_fault = 0;
        end else if (rd) begin
            m_halted = 1; m_fault = 1; m_shown_valid = 0;
        end else if (hl) begin
            m_halted = 1; m_shown_valid = 0;
        end else if (!st && !m_halted) begin
            m_shown = m_next; m_shown_valid = 1; m_next = m_next + 4; m_boot = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_pc", imem_pc, e.imem_pc);
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
            chk("id_instruction", id_instruction, e.instr);
            chk("id_pc", id_pc, e.pc);
            chk("id_pc_plus4", id_pc_plus4, e.pc4);
            chk("fault", {31'd0, fault}, {31'd0, e.fault});
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, e.pf);
            chk("perf_stalls", perf_stalls, e.ps);
            chk("perf_redirects", perf_redirects, e.pr);
`endif
        end
    end

    initial begin
        logic [31:0] rpc;
        int          r;
        repeat (2) @(posedge clk);
        model_reset(32'h0);

        // Boot fetch, then a 3-cycle stall while id_pc=4, then release.
        repeat (2) step(0, 0, 0, 32'h0, 0);
        repeat (3) step(0, 1, 0, 32'h0, 0);
        repeat (2) step(0, 0, 0, 32'h0, 0);
        // Redirect wins over stall.
        step(0, 1, 1, 32'h40, 0);
        repeat (2) step(0, 0, 0, 32'h0, 0);
        // Misaligned target faults and halts; aligned redirect clears it.
        step(0, 0, 1, 32'h42, 0);
        repeat (5) step(0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h0, 0);
        repeat (2) step(0, 0, 0, 32'h0, 0);
        // Halt pulse, then reset out of HALT and replay boot.
        step(0, 0, 0, 32'h0, 1);
        repeat (4) step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        repeat (4) step(0, 0, 0, 32'h0, 0);

        for (int i = 0; i < 1500; i++) begin
            r   = $urandom_range(0, 99);
            rpc = (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE0 : 32'h0) +
                  ($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 3) == 0) rpc = rpc + $urandom_range(1, 3);
            step(r < 1, $urandom_range(0, 3) == 0, (r >= 1) && (r < 9), rpc,
                 (r >= 9) && (r < 12));
        end
        @(posedge clk);
        #2;
        reset = 0; stall = 0; redirect = 0; halt = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        // Wrap instance: held in reset since time 0.
        @(posedge clk);
        #2;
        w_reset = 0;
        @(negedge clk);
        chk("wrap_boot_valid", {31'd0, w_id_valid}, 32'd0);
        chk("wrap_boot_imem_pc", w_imem_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc0", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc0_plus4", w_id_pc_plus4, 32'h0000_0000);
        chk("wrap_valid", {31'd0, w_id_valid}, 32'd1);
        @(negedge clk);
        chk("wrap_pc1", w_id_pc, 32'h0000_0000);
        chk("wrap_pc1_plus4", w_id_pc_plus4, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
